regfile_wb_scheduler: RTL and testbench
=======================================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock, shared with RegisterFile.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iss_valid  input  1  instruction presented for issue.
REQ-005 iss_wr  input  1  issuing instruction writes iss_rd.
REQ-006 iss_rd, iss_ra, iss_rb  input  5 each  destination and source register numbers.
REQ-007 iss_stall  output  1  issue blocked this cycle (combinational).
REQ-008 alu_valid  input  1; alu_rd  input  5; alu_data  input  64: ALU writeback request.
REQ-009 alu_ready  output  1  ALU request granted this cycle (combinational).
REQ-010 mem_valid  input  1; mem_rd  input  5; mem_data  input  64: load-unit writeback request.
REQ-011 mem_ready  output  1  load request granted this cycle (combinational).
REQ-012 RegWr  output  1; RW  output  5; BusW  output  64: registered drive of the RegisterFile write port.
REQ-013 sb_err  output  1  sticky flag: writeback to a register not marked busy.

Function
REQ-014 The block SHALL keep a 32-bit scoreboard busy[31:0]; busy[31] is hard-wired to 0.
REQ-015 iss_stall SHALL be 1 when iss_valid=1 and any of busy[iss_ra], busy[iss_rb], or (iss_wr and busy[iss_rd]) is 1; otherwise 0.
REQ-016 Issue acceptance SHALL be iss_valid && !iss_stall; on acceptance with iss_wr=1 and iss_rd!=31, busy[iss_rd] SHALL be set at the next edge.
REQ-017 Arbitration: with one requester valid, that requester is granted; with both valid, the requester named by round-robin pointer rr is granted.
REQ-018 rr SHALL update only when both requesters are valid in the same cycle, and SHALL then point to the requester not granted.
REQ-019 At most one of alu_ready/mem_ready SHALL be 1 in any cycle; a ready SHALL never be 1 while its valid is 0.
REQ-020 A granted request SHALL appear on RW/BusW at the next edge (latency 1); RegWr SHALL be 1 for that cycle only if the granted rd != 31.
REQ-021 With no grant, RegWr SHALL be 0 at the next edge; RW/BusW SHALL hold their previous values.
REQ-022 busy[RW] SHALL clear at the edge that ends a cycle in which RegWr=1.
REQ-023 If set (REQ-016) and clear (REQ-022) target the same register at the same edge, set SHALL win.
REQ-024 If a grant occurs for rd!=31 while busy[rd]=0, sb_err SHALL be set at the next edge and hold until reset; the write still proceeds.
REQ-025 Requesters SHALL hold valid/rd/data stable until ready; the block does not buffer ungranted requests.

Reset
REQ-026 When reset=1 at an edge: busy=0, RegWr=0, RW=0, BusW=0, sb_err=0, rr=load-unit priority.
REQ-027 During reset, alu_ready=mem_ready=0 and iss_stall=1 when iss_valid=1; requests in flight are discarded without a write.

Configuration
REQ-028 Macro WB_BYPASS_EN: when defined, a source or destination whose busy bit is set SHALL NOT cause a stall if RegWr=1 and RW equals that register in the same cycle, because RegisterFile forwards BusW.
REQ-029 Without WB_BYPASS_EN, REQ-015 SHALL apply unmodified, and busy registers stall until the cycle after RegWr.

Verification
REQ-030 Issue rd=5 wr=1, then issue ra=5 next cycle -> iss_stall=1; the ALU writes x5=0xA5 -> RegWr=1, RW=5, BusW=0xA5 one cycle after alu_ready; the stall drops the cycle after that edge, or on the RegWr cycle with WB_BYPASS_EN.
REQ-031 Hold alu_valid and mem_valid for 4 cycles after reset -> grants alternate mem, alu, mem, alu.
REQ-032 Issue rd=7 on the same edge that busy[7] clears (WB_BYPASS_EN) -> busy[7]=1 afterwards.
REQ-033 mem_valid with mem_rd=31 -> mem_ready=1, RegWr=0 next cycle, busy unchanged, sb_err=0.
REQ-034 alu_valid with alu_rd=3 and busy[3]=0 -> sb_err=1 next cycle and remains 1 until reset.
REQ-035 Assert reset with busy[9]=1 and mem_valid pending -> the next cycle has busy=0, RegWr=0, and no write of the pending data.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter and register scoreboard in front of the RegisterFile write port.
// Optional macro WB_BYPASS_EN: a register being written this cycle does not stall issue.
module regfile_wb_scheduler #(
  parameter int DATA_W = 64
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [4:0]        iss_rd,
  input  logic [4:0]        iss_ra,
  input  logic [4:0]        iss_rb,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              RegWr,
  output logic [4:0]        RW,
  output logic [DATA_W-1:0] BusW,
  output logic              sb_err
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic [31:0]       r_busy;
  logic              r_rr;
  logic              r_regwr;
  logic [4:0]        r_rw;
  logic [DATA_W-1:0] r_busw;
  logic              r_sb_err;

  logic [31:0]       w_wb_mask;
  logic [31:0]       w_busy_eff;
  logic [31:0]       w_set_mask;
  logic [31:0]       w_busy_nxt;
  logic              w_hazard;
  logic              w_accept;
  logic              w_alu_gnt;
  logic              w_mem_gnt;
  logic              w_gnt;
  logic              w_both;
  logic [4:0]        w_gnt_rd;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_gnt_wr;
  logic              w_sb_hit;

  // One-hot of the register the RegisterFile is writing this cycle.
  always_comb begin
    w_wb_mask = '0;
    if (r_regwr) w_wb_mask[r_rw] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_wb_mask;
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_hazard  = w_busy_eff[iss_ra] | w_busy_eff[iss_rb] | (iss_wr & w_busy_eff[iss_rd]);
  assign iss_stall = iss_valid & (reset | w_hazard);
  assign w_accept  = iss_valid & ~iss_stall;

  // r_rr = 1 prefers the ALU on a contested cycle, 0 prefers the load unit.
  assign w_both = alu_valid & mem_valid & ~reset;

  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        w_alu_gnt = r_rr;
        w_mem_gnt = ~r_rr;
      end else begin
        w_alu_gnt = alu_valid;
        w_mem_gnt = mem_valid;
      end
    end
  end

  assign alu_ready  = w_alu_gnt;
  assign mem_ready  = w_mem_gnt;
  assign w_gnt      = w_alu_gnt | w_mem_gnt;
  assign w_gnt_rd   = w_alu_gnt ? alu_rd : mem_rd;
  assign w_gnt_data = w_alu_gnt ? alu_data : mem_data;
  assign w_gnt_wr   = w_gnt & (w_gnt_rd != ZERO_REG);
  assign w_sb_hit   = w_gnt_wr & ~r_busy[w_gnt_rd];

  always_comb begin
    w_set_mask = '0;
    if (w_accept && iss_wr && (iss_rd != ZERO_REG)) w_set_mask[iss_rd] = 1'b1;
  end

  // Clear first, then set, so an issue to the register retiring this edge stays busy.
  always_comb begin
    w_busy_nxt     = (r_busy & ~w_wb_mask) | w_set_mask;
    w_busy_nxt[31] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_busy   <= '0;
      r_rr     <= 1'b0;
      r_regwr  <= 1'b0;
      r_rw     <= '0;
      r_busw   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_regwr <= w_gnt_wr;
      if (w_both) r_rr <= w_mem_gnt;
      if (w_gnt) begin
        r_rw   <= w_gnt_rd;
        r_busw <= w_gnt_data;
      end
      if (w_sb_hit) r_sb_err <= 1'b1;
    end
  end

  assign RegWr  = r_regwr;
  assign RW     = r_rw;
  assign BusW   = r_busw;
  assign sb_err = r_sb_err;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: randomized traffic against a cycle-level reference model.
module tb_regfile_wb_scheduler;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        reset;
  logic        iss_valid, iss_wr;
  logic [4:0]  iss_rd, iss_ra, iss_rb;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        sb_err;

  regfile_wb_scheduler #(.DATA_W(64)) dut (
    .Clk(Clk), .reset(reset),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_ra(iss_ra), .iss_rb(iss_rb),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWr(RegWr), .RW(RW), .BusW(BusW), .sb_err(sb_err)
  );

  typedef struct { logic [4:0] rd; logic [63:0] data; } wb_t;
  wb_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: which registers await a result, the write in flight, and contest count.
  bit          m_busy[32];
  int          m_pend;
  logic [4:0]  m_rw;
  logic [63:0] m_busw;
  bit          m_err;
  int          m_contests;
  bit          g_alu, g_mem;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit eff_busy(input int r);
`ifdef WB_BYPASS_EN
    if (m_pend == r) return 1'b0;
`endif
    return m_busy[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_pend     = -1;
    m_rw       = '0;
    m_busw     = '0;
    m_err      = 1'b0;
    m_contests = 0;
  endtask

  // Check the current cycle against the model, advance the model, and move past the edge.
  task automatic step();
    bit          ea, em, es;
    bit          old_busy[32];
    logic [4:0]  grd;
    logic [63:0] gd;
    wb_t         e;
    #2;
    ea = 1'b0; em = 1'b0;
    if (reset) es = iss_valid;
    else begin
      es = iss_valid && (eff_busy(int'(iss_ra)) || eff_busy(int'(iss_rb)) ||
                         (iss_wr && eff_busy(int'(iss_rd))));
      if (alu_valid && mem_valid) begin
        if (m_contests % 2 == 0) em = 1'b1; else ea = 1'b1;
      end else begin
        ea = alu_valid;
        em = mem_valid;
      end
    end
    check("iss_stall", 64'(iss_stall), 64'(es));
    check("alu_ready", 64'(alu_ready), 64'(ea));
    check("mem_ready", 64'(mem_ready), 64'(em));
    check("RegWr",     64'(RegWr),     64'(m_pend >= 0));
    check("RW",        64'(RW),        64'(m_rw));
    check("BusW",      BusW,           m_busw);
    check("sb_err",    64'(sb_err),    64'(m_err));
    g_alu = ea;
    g_mem = em;
    if (reset) model_reset();
    else begin
      old_busy = m_busy;
      if (m_pend >= 0) m_busy[m_pend] = 1'b0;
      if (iss_valid && !es && iss_wr && iss_rd != 5'd31) m_busy[iss_rd] = 1'b1;
      if (alu_valid && mem_valid) m_contests++;
      m_pend = -1;
      if (ea || em) begin
        grd    = ea ? alu_rd : mem_rd;
        gd     = ea ? alu_data : mem_data;
        m_rw   = grd;
        m_busw = gd;
        if (grd != 5'd31) begin
          m_pend = int'(grd);
          e.rd   = grd;
          e.data = gd;
          exp_q.push_back(e);
          if (!old_busy[grd]) m_err = 1'b1;
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every RegisterFile write must match the oldest expected grant.
  initial begin
    wb_t e;
    forever begin
      @(negedge Clk);
      if (RegWr === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL wb_unexpected: RW=%0d BusW=%0h, no write expected", RW, BusW);
        end else begin
          e = exp_q.pop_front();
          check("wb_RW",   64'(RW), 64'(e.rd));
          check("wb_BusW", BusW,    e.data);
        end
      end
    end
  end

  function automatic logic [4:0] pick_reg();
    int cand[$];
    int r;
    for (int i = 0; i < 31; i++) if (m_busy[i]) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(0, 3) != 0)
      return 5'(cand[$urandom_range(0, cand.size() - 1)]);
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [4:0] rand_src();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  task automatic idle_inputs();
    iss_valid = 0; iss_wr = 0; iss_rd = 0; iss_ra = 0; iss_rb = 0;
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    mem_valid = 0; mem_rd = 0; mem_data = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    g_alu = 0; g_mem = 0;
    @(posedge Clk);
    #1;
    model_reset();
    reset = 1'b0;
    step();

    // Dependent issue stalls until the ALU writeback of x5 retires.
    iss_valid = 1; iss_wr = 1; iss_rd = 5; step();
    iss_wr = 0; iss_rd = 0; iss_ra = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 64'hA5; step();
    alu_valid = 0; step();
    step();
    iss_valid = 0; iss_ra = 0; step();

    // Contested arbitration after reset alternates starting with the load unit.
    reset = 1; step();
    reset = 0;
    alu_valid = 1; alu_rd = 31; alu_data = 64'h1111;
    mem_valid = 1; mem_rd = 31; mem_data = 64'h2222;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("rr_seq_mem", 64'(mem_ready), 64'(i % 2 == 0));
      check("rr_seq_alu", 64'(alu_ready), 64'(i % 2 == 1));
      step();
    end
    alu_valid = 0; mem_valid = 0; step();

    // Load to x31: granted, no write, no error.
    mem_valid = 1; mem_rd = 31; mem_data = 64'hDEAD; step();
    mem_valid = 0; step();

    // Issue to x7 on the edge where its busy bit clears.
    iss_valid = 1; iss_wr = 1; iss_rd = 7; step();
    iss_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 64'h77; step();
    alu_valid = 0; iss_valid = 1; iss_wr = 1; iss_rd = 7; step();
    step();
    iss_wr = 0; iss_rd = 0; iss_ra = 7; step();
    iss_valid = 0; iss_ra = 0; step();

    // Writeback to a non-busy register sets the sticky error.
    alu_valid = 1; alu_rd = 3; alu_data = 64'h33; step();
    alu_valid = 0; step(); step(); step();
    check("sb_err_sticky", 64'(sb_err), 64'd1);

    // Reset discards a pending load and clears the scoreboard.
    iss_valid = 1; iss_wr = 1; iss_rd = 9; step();
    iss_valid = 0; iss_wr = 0; iss_rd = 0;
    mem_valid = 1; mem_rd = 9; mem_data = 64'h9999; reset = 1; step();
    reset = 0; mem_valid = 0; step();
    check("sb_err_cleared", 64'(sb_err), 64'd0);

    // Randomized traffic; requesters hold until granted.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!alu_valid || g_alu) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = pick_reg();
        alu_data  = {$urandom, $urandom};
      end
      if (!mem_valid || g_mem) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = pick_reg();
        mem_data  = {$urandom, $urandom};
      end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_wr    = ($urandom_range(0, 2) != 0);
      iss_rd    = rand_src();
      iss_ra    = rand_src();
      iss_rb    = rand_src();
      step();
    end

    reset = 0;
    idle_inputs();
    step(); step(); step();
    check("wb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
